// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - single-outstanding instruction fetch FSM feeding a PC-tagged FIFO
module instr_fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 64,
  parameter int INST_W = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [ADDR_W-1:0]         pc,
  output logic                      pc_take,
  input  logic                      flush,
  output logic                      imem_req,
  output logic [ADDR_W-1:0]         imem_addr,
  input  logic                      imem_gnt,
  input  logic                      imem_rvalid,
  input  logic [INST_W-1:0]         imem_rdata,
  output logic                      inst_valid,
  output logic [INST_W-1:0]         inst,
  output logic [ADDR_W-1:0]         inst_pc,
  input  logic                      inst_ready,
  output logic [$clog2(DEPTH):0]    queue_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

  state_t             state;
  logic [ADDR_W-1:0]  req_pc;
  logic [INST_W-1:0]  mem_inst [DEPTH];
  logic [ADDR_W-1:0]  mem_pc   [DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_next;
  logic               push;
  logic               pop;

  assign imem_req    = (state == REQ);
  assign imem_addr   = req_pc;
  assign pc_take     = imem_req & imem_gnt & ~flush;
  assign inst_valid  = (count != '0);
  assign inst        = mem_inst[head];
  assign inst_pc     = mem_pc[head];
  assign queue_count = count;

  // Flush wins over both push and pop; the FIFO is cleared on that edge.
  assign push       = (state == WAIT) & imem_rvalid & ~flush;
  assign pop        = inst_valid & inst_ready & ~flush;
  assign count_next = count + CNT_W'(push) - CNT_W'(pop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      req_pc <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!flush && count < CNT_W'(DEPTH)) begin
            state  <= REQ;
            req_pc <= pc;
          end
        end
        REQ: begin
          if (imem_gnt)   state <= flush ? DRAIN : WAIT;
          else if (flush) state <= IDLE;
        end
        WAIT: begin
          if (flush) begin
            state <= imem_rvalid ? IDLE : DRAIN;
          end else if (imem_rvalid) begin
            // Space check uses the post-push/pop occupancy so a granted fetch always has a slot.
            if (count_next < CNT_W'(DEPTH)) begin
              state  <= REQ;
              req_pc <= pc;
            end else begin
              state <= IDLE;
            end
          end
        end
        DRAIN: begin
          if (imem_rvalid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_inst[i] <= '0;
        mem_pc[i]   <= '0;
      end
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem_inst[tail] <= imem_rdata;
        mem_pc[tail]   <= req_pc;
        tail           <= tail + PTR_W'(1);
      end
      if (pop) head <= head + PTR_W'(1);
      count <= count_next;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - directed scenarios plus randomized run against a queue reference model
module tb_instr_fetch_queue;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] pc;
  logic        pc_take;
  logic        flush;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_ready;
  logic [2:0]  queue_count;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [63:0] a;
    logic [31:0] d;
  } ent_t;

  instr_fetch_queue #(.DEPTH(4), .ADDR_W(64), .INST_W(32)) dut (
    .clock(clock), .reset(reset), .pc(pc), .pc_take(pc_take), .flush(flush),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
    .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready), .queue_count(queue_count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input logic [63:0] start_pc);
    reset = 1'b1; pc = start_pc; flush = 0; imem_gnt = 0; imem_rvalid = 0;
    imem_rdata = '0; inst_ready = 0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'hC0DE_0013;
  endfunction

  task automatic fetch_one(input logic [31:0] data, output logic [63:0] addr);
    int n = 0;
    while (!imem_req && n < 20) begin
      tick();
      n++;
    end
    tests++;
    if (imem_req !== 1'b1) begin
      fails++;
      $display("FAIL fetch_req_timeout: imem_req=%b want 1", imem_req);
      addr = 'x;
      return;
    end
    addr = imem_addr;
    imem_gnt = 1; tick(); imem_gnt = 0; pc = pc + 64'd4;
    imem_rvalid = 1; imem_rdata = data; tick(); imem_rvalid = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; pc = 64'h1234; flush = 0; imem_gnt = 1; imem_rvalid = 0;
    imem_rdata = '0; inst_ready = 1;
    #3;
    tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL rst_req: got %b want 0", imem_req); end
    tests++; if (pc_take !== 1'b0) begin fails++; $display("FAIL rst_pc_take: got %b want 0", pc_take); end
    tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", inst_valid); end
    tests++; if (queue_count !== 3'd0) begin fails++; $display("FAIL rst_count: got %0d want 0", queue_count); end
    tests++; if (imem_addr !== 64'h0) begin fails++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
    tests++; if (inst !== 32'h0 || inst_pc !== 64'h0) begin fails++; $display("FAIL rst_head: got %h/%h want 0/0", inst, inst_pc); end
  endtask

  task automatic test_basic_fetch();
    do_reset(64'h1000);
    tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL basic_c0_req: got %b want 0", imem_req); end
    tick();
    tests++; if (imem_req !== 1'b1 || imem_addr !== 64'h1000) begin fails++; $display("FAIL basic_c1_req: got %b/%h want 1/1000", imem_req, imem_addr); end
    imem_gnt = 1; #1;
    tests++; if (pc_take !== 1'b1) begin fails++; $display("FAIL basic_pc_take: got %b want 1", pc_take); end
    tick(); imem_gnt = 0; pc = 64'h1004;
    tests++; if (imem_req !== 1'b0 || pc_take !== 1'b0) begin fails++; $display("FAIL basic_c2: req=%b take=%b want 0/0", imem_req, pc_take); end
    imem_rvalid = 1; imem_rdata = 32'hA000_0013; inst_ready = 1;
    tick(); imem_rvalid = 0;
    tests++; if (inst_valid !== 1'b1 || inst !== 32'hA000_0013 || inst_pc !== 64'h1000) begin fails++; $display("FAIL basic_c3: valid=%b inst=%h pc=%h want 1/a0000013/1000", inst_valid, inst, inst_pc); end
    tick(); inst_ready = 0;
    tests++; if (queue_count !== 3'd0) begin fails++; $display("FAIL basic_pop: got %0d want 0", queue_count); end
  endtask

  task automatic test_fill_backpressure();
    logic [63:0] a;
    do_reset(64'h0);
    for (int i = 0; i < 4; i++) begin
      fetch_one(32'h100 + 32'(i), a);
      tests++; if (a !== 64'(i * 4)) begin fails++; $display("FAIL fill_addr%0d: got %h want %h", i, a, i * 4); end
    end
    tests++; if (queue_count !== 3'd4) begin fails++; $display("FAIL fill_count: got %0d want 4", queue_count); end
    for (int i = 0; i < 3; i++) begin
      tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL full_no_req: got %b want 0", imem_req); end
      tick();
    end
    tests++; if (inst_pc !== 64'h0 || inst !== 32'h100) begin fails++; $display("FAIL fill_head0: got %h/%h want 0/100", inst_pc, inst); end
    inst_ready = 1; tick(); inst_ready = 0;
    tests++; if (imem_req !== 1'b0 || queue_count !== 3'd3) begin fails++; $display("FAIL post_pop: req=%b cnt=%0d want 0/3", imem_req, queue_count); end
    tick();
    tests++; if (imem_req !== 1'b1 || imem_addr !== 64'h10) begin fails++; $display("FAIL resume: req=%b addr=%h want 1/10", imem_req, imem_addr); end
    fetch_one(32'h104, a);
    for (int i = 1; i <= 4; i++) begin
      tests++; if (inst_valid !== 1'b1 || inst_pc !== 64'(i * 4) || inst !== 32'h100 + 32'(i)) begin fails++; $display("FAIL order%0d: got %b/%h/%h want 1/%h/%h", i, inst_valid, inst_pc, inst, i * 4, 32'h100 + 32'(i)); end
      inst_ready = 1; tick(); inst_ready = 0;
    end
  endtask

  task automatic test_grant_stall();
    do_reset(64'h2000);
    tick();
    for (int i = 0; i < 5; i++) begin
      tests++; if (imem_req !== 1'b1 || imem_addr !== 64'h2000 || pc_take !== 1'b0) begin fails++; $display("FAIL stall%0d: req=%b addr=%h take=%b want 1/2000/0", i, imem_req, imem_addr, pc_take); end
      tick();
    end
    flush = 1; pc = 64'h3000; tick(); flush = 0;
    tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL withdraw: got %b want 0", imem_req); end
    tick();
    tests++; if (imem_req !== 1'b1 || imem_addr !== 64'h3000) begin fails++; $display("FAIL withdraw_reissue: got %b/%h want 1/3000", imem_req, imem_addr); end
  endtask

  task automatic test_flush_wait();
    logic [63:0] a;
    do_reset(64'h0);
    fetch_one(32'h11, a);
    fetch_one(32'h22, a);
    tests++; if (queue_count !== 3'd2) begin fails++; $display("FAIL fw_count2: got %0d want 2", queue_count); end
    imem_gnt = 1; tick(); imem_gnt = 0; pc = pc + 64'd4;
    flush = 1; pc = 64'h8000; tick(); flush = 0;
    tests++; if (queue_count !== 3'd0 || inst_valid !== 1'b0) begin fails++; $display("FAIL fw_cleared: cnt=%0d valid=%b want 0/0", queue_count, inst_valid); end
    tick();
    imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF; tick(); imem_rvalid = 0;
    tests++; if (queue_count !== 3'd0 || inst_valid !== 1'b0 || imem_req !== 1'b0) begin fails++; $display("FAIL fw_drained: cnt=%0d valid=%b req=%b want 0/0/0", queue_count, inst_valid, imem_req); end
    tick();
    tests++; if (imem_req !== 1'b1 || imem_addr !== 64'h8000) begin fails++; $display("FAIL fw_redirect: got %b/%h want 1/8000", imem_req, imem_addr); end
    fetch_one(32'h55, a);
    tests++; if (queue_count !== 3'd1 || inst !== 32'h55 || inst_pc !== 64'h8000) begin fails++; $display("FAIL fw_newdata: cnt=%0d inst=%h pc=%h want 1/55/8000", queue_count, inst, inst_pc); end
  endtask

  task automatic test_flush_gnt();
    do_reset(64'h4000);
    tick();
    imem_gnt = 1; flush = 1; #1;
    tests++; if (pc_take !== 1'b0) begin fails++; $display("FAIL fg_pc_take: got %b want 0", pc_take); end
    pc = 64'h5000;
    tick(); imem_gnt = 0; flush = 0;
    for (int i = 0; i < 3; i++) begin
      tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL fg_drain%0d: req=%b want 0", i, imem_req); end
      tick();
    end
    imem_rvalid = 1; imem_rdata = 32'h0000_0BAD; tick(); imem_rvalid = 0;
    tests++; if (queue_count !== 3'd0) begin fails++; $display("FAIL fg_discard: got %0d want 0", queue_count); end
    tick();
    tests++; if (imem_req !== 1'b1 || imem_addr !== 64'h5000) begin fails++; $display("FAIL fg_reissue: got %b/%h want 1/5000", imem_req, imem_addr); end
  endtask

  task automatic test_push_pop();
    logic [63:0] a;
    do_reset(64'h0);
    fetch_one(32'h1, a);
    fetch_one(32'h2, a);
    imem_gnt = 1; tick(); imem_gnt = 0; pc = pc + 64'd4;
    imem_rvalid = 1; imem_rdata = 32'h33; inst_ready = 1; tick(); imem_rvalid = 0; inst_ready = 0;
    tests++; if (queue_count !== 3'd2 || inst_pc !== 64'h4) begin fails++; $display("FAIL pushpop: cnt=%0d head=%h want 2/4", queue_count, inst_pc); end
  endtask

  task automatic test_async_reset();
    logic [63:0] a;
    do_reset(64'h6000);
    fetch_one(32'h66, a);
    imem_gnt = 1; tick(); imem_gnt = 0; pc = pc + 64'd4;
    #2; reset = 1'b1; #1;
    tests++; if (queue_count !== 3'd0 || inst_valid !== 1'b0 || imem_req !== 1'b0) begin fails++; $display("FAIL ar_immediate: cnt=%0d valid=%b req=%b want 0/0/0", queue_count, inst_valid, imem_req); end
    tests++; if (imem_addr !== 64'h0 || inst_pc !== 64'h0 || inst !== 32'h0) begin fails++; $display("FAIL ar_values: addr=%h pc=%h inst=%h want 0", imem_addr, inst_pc, inst); end
    @(posedge clock); #1; reset = 1'b0;
    imem_rvalid = 1; imem_rdata = 32'h77; tick(); imem_rvalid = 0;
    tests++; if (queue_count !== 3'd0 || inst_valid !== 1'b0) begin fails++; $display("FAIL ar_late_rvalid: cnt=%0d valid=%b want 0/0", queue_count, inst_valid); end
  endtask

  task automatic test_random();
    ent_t        q[$];
    logic        outstanding = 0;
    logic        dropped = 0;
    logic [63:0] pend_addr = '0;
    logic [63:0] new_pc;
    logic        took;
    int          grants = 0;
    do_reset(64'h100);
    for (int i = 0; i < 3000; i++) begin
      inst_ready = ($urandom_range(0, 9) < (((i / 300) % 2) ? 8 : 2));
      flush      = ($urandom_range(0, 29) == 0);
      imem_gnt   = $urandom_range(0, 1);
      new_pc     = {32'h0, $urandom} & ~64'h3;
      if (outstanding) begin
        imem_rvalid = ($urandom_range(0, 2) == 0);
        imem_rdata  = mem_word(pend_addr);
      end else begin
        imem_rvalid = ($urandom_range(0, 15) == 0);
        imem_rdata  = $urandom;
      end
      #1;
      tests++; if (queue_count !== 3'(q.size())) begin fails++; $display("FAIL rnd_count@%0d: got %0d want %0d", i, queue_count, q.size()); end
      tests++; if (inst_valid !== (q.size() != 0)) begin fails++; $display("FAIL rnd_valid@%0d: got %b want %b", i, inst_valid, q.size() != 0); end
      if (q.size() != 0) begin
        tests++; if (inst !== q[0].d || inst_pc !== q[0].a) begin fails++; $display("FAIL rnd_head@%0d: got %h/%h want %h/%h", i, inst, inst_pc, q[0].d, q[0].a); end
      end
      tests++; if (pc_take !== (imem_req & imem_gnt & ~flush)) begin fails++; $display("FAIL rnd_pc_take@%0d: got %b want %b", i, pc_take, imem_req & imem_gnt & ~flush); end
      if (imem_req) begin
        tests++; if (imem_addr !== pc || outstanding || q.size() >= 4) begin fails++; $display("FAIL rnd_req@%0d: addr=%h pc=%h outst=%b size=%0d", i, imem_addr, pc, outstanding, q.size()); end
      end
      took = imem_req & imem_gnt & ~flush;
      if (flush) begin
        q.delete();
        if (imem_req && imem_gnt) begin
          outstanding = 1; dropped = 1;
        end else if (outstanding && imem_rvalid) begin
          outstanding = 0;
        end else if (outstanding) begin
          dropped = 1;
        end
      end else begin
        if (q.size() != 0 && inst_ready) void'(q.pop_front());
        if (outstanding && imem_rvalid) begin
          if (!dropped) q.push_back('{a: pend_addr, d: mem_word(pend_addr)});
          outstanding = 0;
        end
        if (took) begin
          outstanding = 1; dropped = 0; pend_addr = pc; grants++;
        end
      end
      tick();
      if (flush) pc = new_pc;
      else if (took) pc = pc + 64'd4;
    end
    flush = 0; imem_gnt = 0; imem_rvalid = 0; inst_ready = 0;
    tests++; if (grants < 100) begin fails++; $display("FAIL rnd_progress: got %0d grants want >=100", grants); end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_fill_backpressure();
    test_grant_stall();
    test_flush_wait();
    test_flush_gnt();
    test_push_pop();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Instruction fetch stage directly downstream of the program counter. Takes the current PC, issues one instruction-memory read at a time over a request/grant/response handshake, and pulses `pc_take` so the PC advances. Each fetched instruction is buffered with its PC in a small FIFO and presented to decode through a valid/ready interface. `flush` discards all queued and in-flight work on a redirect.

## Interface
- `DEPTH`, 4: FIFO entries (power of two, ≥2)
- `ADDR_W`, 64: PC/address width
- `INST_W`, 32: instruction width
- `clock`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `pc`  in  ADDR_W  current PC (program counter `pc_out`)
- `pc_take`  out  1  PC consumed this cycle; PC advances to PC+4
- `flush`  in  1  redirect: drop queue and outstanding fetch
- `imem_req`  out  1  memory read request
- `imem_addr`  out  ADDR_W  request address
- `imem_gnt`  in  1  request accepted this cycle
- `imem_rvalid`  in  1  response data valid
- `imem_rdata`  in  INST_W  response instruction
- `inst_valid`  out  1  head entry valid
- `inst`  out  INST_W  head instruction
- `inst_pc`  out  ADDR_W  PC of head instruction
- `inst_ready`  in  1  decode accepts head this cycle
- `queue_count`  out  clog2(DEPTH)+1  occupied entries

## Operation
- FSM states:
  - IDLE: no request.
  - REQ: `imem_req`=1.
  - WAIT: granted, awaiting response.
  - DRAIN: discard one pending response.
- At most one request is outstanding. The space check guarantees a slot for every granted request.
- IDLE → REQ when `!flush && queue_count < DEPTH`. On the transition, `pc` is latched into `req_pc`.
- REQ:
  - `imem_addr = req_pc`, held stable until grant.
  - `pc_take = imem_req & imem_gnt & ~flush`, combinational.
  - On `gnt & ~flush`: go to WAIT.
  - On `gnt & flush`: go to DRAIN; `pc_take` stays 0.
  - On `~gnt & flush`: withdraw the request and go to IDLE. Withdrawing before grant is legal for the memory.
- WAIT:
  - On `rvalid & ~flush`: write `{req_pc, rdata}` at the tail.
  - Next state is REQ (latching `pc`) if post-update count < DEPTH, else IDLE.
  - On `rvalid & flush`: data dropped, go to IDLE.
  - On `~rvalid & flush`: go to DRAIN.
- DRAIN: the next `rvalid` is discarded, then go to IDLE. `flush` while in DRAIN keeps DRAIN.
- `imem_rvalid` in IDLE or REQ is ignored (protocol violation).
- FIFO:
  - Pop when `inst_valid & inst_ready`.
  - Push and pop in the same cycle leaves the count unchanged.
  - Pointers wrap modulo DEPTH.
  - `inst_valid = (count != 0)`; `inst` and `inst_pc` come from the head entry.
- Flush:
  - Clears the FIFO (count 0, pointers 0) on the same edge.
  - Overrides any pop or push in that cycle.
  - `inst_valid` is 0 the cycle after a flush.
- Reset values:
  - State IDLE.
  - `imem_req`, `pc_take`, `inst_valid` = 0.
  - `queue_count` = 0; pointers 0; `req_pc` = 0, so `imem_addr` = 0.
  - All entries 0, so `inst` = 0 and `inst_pc` = 0.
  - Reset asserted mid-fetch abandons the fetch. A response arriving after reset release is ignored (IDLE).

## Timing
- Registered: state, `req_pc`, FIFO storage, pointers, count.
- Combinational: `imem_req` (from state), `pc_take`, `inst_valid`.
- Minimum latency, with `gnt` and `rvalid` each in the first cycle they can occur:
  - Cycle 0: IDLE with space.
  - Cycle 1: REQ, `gnt`.
  - Cycle 2: WAIT, `rvalid`.
  - Cycle 3: `inst_valid`=1.
- Sustained throughput is 1 instruction per 2 cycles (REQ→WAIT→REQ).
- `pc` must be stable in the cycle the FSM enters REQ. The PC updates only on `pc_take`.
- Full: with `queue_count` = DEPTH, no request is issued. Issue resumes the cycle after a pop: REQ one cycle after the pop edge.

## Test plan
- Basic fetch, reset then release:
  - Stimulus: `pc`=0x1000, `gnt` immediate, `rvalid` next cycle with rdata 0xA000_0013, `inst_ready`=1.
  - Response: `imem_addr`=0x1000, `pc_take` pulses once, cycle 3 shows `inst`=0xA000_0013, `inst_pc`=0x1000.
- Fill and back-pressure:
  - Stimulus: `inst_ready`=0, PC stepping 0x0, 0x4, 0x8, 0xC.
  - Response: after 4 fetches `queue_count`=4 and `imem_req` stays 0.
  - Then one pop: next request has `imem_addr`=0x10 and FIFO order 0x0, 0x4, 0x8, 0xC is preserved.
- Grant stall: hold `gnt`=0 for 5 cycles → `imem_req`=1 and `imem_addr` constant, `pc_take`=0 throughout.
- Flush in WAIT:
  - Stimulus: flush with 2 entries queued; `rvalid` arrives 2 cycles later with 0xDEAD_BEEF.
  - Response: `queue_count`=0 the next cycle, 0xDEAD_BEEF never appears, next request uses the new `pc`=0x8000.
- Simultaneous events:
  - `flush` & `gnt` in the same cycle → `pc_take`=0, state DRAIN.
  - Push and pop in the same cycle at count 2 → count stays 2.
- Reset mid-operation: assert `reset` asynchronously during WAIT → outputs immediately at reset values; a late `rvalid` is ignored.
